encoder_8to3_seq: RTL and testbench
===================================

Name: encoder_8to3_seq

Overview:
- Registered 8-to-3 priority encoder. It is the inverse of the existing 3-to-8 decoder path.
- Captures one-hot or multi-hot request lines into a sticky pending register.
- Emits the encoded index of the highest-priority pending line over a valid/ready handshake.
- Clears each line once it has been consumed. Used wherever decoder outputs or per-line events must be converted back to a binary index.

Parameters:
N, 8, number of request lines (fixed at 8 for this release)
CODE_W, 3, width of the encoded index (log2 N)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
en  input  1  request capture enable; new requests ignored while 0
req  input  8  request lines, bit i = line Yi; level-sampled each cycle
out_code  output  3  encoded index of the line being presented
out_valid  output  1  out_code is valid and held stable
out_ready  input  1  consumer accepts out_code when out_valid & out_ready
pending  output  8  current sticky pending register (registered)
busy  output  1  |pending | out_valid (combinational from registers)
dropped  output  1  sticky flag: a request hit an already-pending line

Behaviour:
- Reset, sync and active-high:
  - On a rising clk with rst=1: pending=0, out_valid=0, out_code=3'b000, dropped=0, FSM=IDLE.
  - Reset takes precedence over every other event. A presented but unaccepted code is discarded, and no handshake completes in a reset cycle.
- Capture:
  - set_mask = req & {8{en}}.
  - clr_mask = onehot(out_code) when (state==HOLD && out_ready), else 0.
  - pending_next = (pending & ~clr_mask) | set_mask. Set wins over clear for the same bit in the same cycle, so a re-request is not lost.
- Drop detect: dropped is set when any bit of (set_mask & pending & ~clr_mask) is 1. It stays 1 until rst.
- Priority: fixed, highest index wins (Y7 highest, Y0 lowest). Selection uses the registered pending value, not pending_next.
- FSM IDLE:
  - out_valid=0.
  - If pending!=0: out_code <= index of highest set bit, out_valid <= 1, go HOLD.
  - Otherwise stay in IDLE; out_code holds its last value.
- FSM HOLD:
  - out_valid=1. out_code is stable until accepted, and higher-priority arrivals do not preempt it.
  - If out_ready: clear bit out_code per clr_mask, out_valid <= 0, go IDLE. Otherwise stay.
- Latency: req sampled in cycle N → pending bit set after edge N → out_valid=1 in cycle N+2.
- Throughput: at most one code per 2 cycles (HOLD→IDLE→HOLD).
- out_ready while out_valid=0 has no effect.
- en=0 blocks capture only. Already-pending lines still drain normally.
- Multi-hot req in one cycle: all bits captured, then drained in descending index order.
- Continuous level req on line i: that line re-pends every cycle it is asserted. This sets dropped on every cycle except the clear cycle.
- No combinational path from req or out_ready to out_code or out_valid.

Test Plan:
1. rst=1 for 2 cycles with req=8'hFF, en=1 → after release: pending=0, out_valid=0, out_code=0, dropped=0.
2. en=1, single-cycle req=8'b0000_0100 at cycle N, out_ready=1 → out_valid=1 with out_code=3'd2 at cycle N+2, then pending=0 and out_valid=0 at N+3.
3. Single-cycle req=8'b1010_0010, out_ready=1 → codes 7, 5, 1 in that order, one every 2 cycles. busy falls after the third acceptance.
4. Backpressure: pend line 3, hold out_ready=0 for 5 cycles, then pulse req line 6 → out_code stays 3 throughout. After out_ready=1, code 6 follows.
5. en=0 with req=8'h01 for 3 cycles → pending stays 0 and out_valid is never asserted. With en=1 and line 4 already pending, a new req=8'h10 (not on the clear cycle) → dropped=1, which stays set until rst.
6. Set/clear collision: HOLD with code 5 while out_ready=1 and req=8'h20 in the same cycle → bit 5 stays pending, dropped stays 0, and code 5 is re-presented 2 cycles later. Asserting rst mid-HOLD → out_valid=0 on the next edge.

Source files
------------

// File: rtl/encoder_8to3_seq.sv
// Registered 8-to-3 priority encoder: sticky pending register drained highest-index first
// over a valid/ready handshake, with a sticky flag for requests that hit a pending line.
module encoder_8to3_seq #(
    parameter int unsigned N      = 8,
    parameter int unsigned CODE_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N-1:0]      req,
    output logic [CODE_W-1:0] out_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      pending,
    output logic              busy,
    output logic              dropped
);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e              state_q, state_d;
    logic [N-1:0]        pending_q, pending_d;
    logic [CODE_W-1:0]   out_code_q, out_code_d;
    logic                out_valid_q, out_valid_d;
    logic                dropped_q, dropped_d;

    logic [N-1:0]        set_mask;
    logic [N-1:0]        clr_mask;
    logic [CODE_W-1:0]   hi_idx;

    always_comb begin
        set_mask = req & {N{en}};
        clr_mask = '0;
        if (state_q == StHold && out_ready) begin
            clr_mask = N'(1) << out_code_q;
        end
        // Set is applied after clear so a same-cycle re-request survives.
        pending_d = (pending_q & ~clr_mask) | set_mask;
        dropped_d = dropped_q | (|(set_mask & pending_q & ~clr_mask));
    end

    // Selection works on the registered pending value; later bits override earlier ones.
    always_comb begin
        hi_idx = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (pending_q[i]) begin
                hi_idx = CODE_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        out_code_d  = out_code_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StIdle: begin
                if (|pending_q) begin
                    out_code_d  = hi_idx;
                    out_valid_d = 1'b1;
                    state_d     = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pending_q   <= '0;
            out_code_q  <= '0;
            out_valid_q <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            out_code_q  <= out_code_d;
            out_valid_q <= out_valid_d;
            dropped_q   <= dropped_d;
        end
    end

    assign out_code  = out_code_q;
    assign out_valid = out_valid_q;
    assign pending   = pending_q;
    assign dropped   = dropped_q;
    assign busy      = (|pending_q) | out_valid_q;

endmodule

// File: tb/tb_encoder_8to3_seq.sv
// Self-checking bench for encoder_8to3_seq: expected codes queued at stimulus time and
// compared on each accepted handshake, plus direct checks of state at key cycles.
module tb_encoder_8to3_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [2:0] out_code;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] pending;
    logic       busy;
    logic       dropped;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2:0] exp_q[$];

    encoder_8to3_seq dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .out_code  (out_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .busy      (busy),
        .dropped   (dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        check("drain_empty", exp_q.size(), 0);
        tick();
    endtask

    // Scoreboard: every completed handshake must match the next queued code.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_code", {29'd0, out_code}, 32'hFFFF_FFFF);
            end else begin
                check("code_order", {29'd0, out_code}, {29'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b1; req = 8'hFF; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0; req = 8'h00;
        check("rst_pending", pending, 8'h00);
        check("rst_valid", out_valid, 0);
        check("rst_code", out_code, 0);
        check("rst_dropped", dropped, 0);
        check("rst_busy", busy, 0);

        // Single request, latency N+2.
        out_ready = 1'b1;
        req = 8'h04; exp_q.push_back(3'd2);
        tick(); req = 8'h00;
        check("t2_pending", pending, 8'h04);
        check("t2_valid_n1", out_valid, 0);
        tick();
        check("t2_valid_n2", out_valid, 1);
        check("t2_code_n2", out_code, 2);
        tick();
        check("t2_pending_n3", pending, 8'h00);
        check("t2_valid_n3", out_valid, 0);

        // Multi-hot drains in descending order, one code per two cycles.
        req = 8'hA2;
        exp_q.push_back(3'd7); exp_q.push_back(3'd5); exp_q.push_back(3'd1);
        tick(); req = 8'h00;
        tick();
        check("t3_code7", out_code, 7);
        tick();
        check("t3_gap_valid", out_valid, 0);
        check("t3_pending_after7", pending, 8'h22);
        tick();
        check("t3_code5", out_code, 5);
        tick(); tick();
        check("t3_code1", out_code, 1);
        check("t3_busy_last", busy, 1);
        tick();
        check("t3_busy_done", busy, 0);
        check("t3_drain", exp_q.size(), 0);

        // Backpressure: presented code is not preempted by a higher line.
        out_ready = 1'b0;
        req = 8'h08; exp_q.push_back(3'd3);
        tick(); req = 8'h00;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                req = 8'h40; exp_q.push_back(3'd6);
            end else begin
                req = 8'h00;
            end
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_code", out_code, 3);
            tick();
        end
        req = 8'h00;
        check("t4_pending", pending, 8'h48);
        out_ready = 1'b1;
        drain(20);
        check("t4_no_drop", dropped, 0);

        // en=0 blocks capture.
        en = 1'b0; req = 8'h01;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_en0_pending", pending, 8'h00);
            check("t5_en0_valid", out_valid, 0);
        end
        en = 1'b1; req = 8'h00; out_ready = 1'b0;
        tick();
        // Re-request of a pending line outside the clear cycle sets dropped.
        req = 8'h10; exp_q.push_back(3'd4);
        tick();
        check("t5_pre_drop", dropped, 0);
        tick(); req = 8'h00;
        check("t5_dropped", dropped, 1);
        out_ready = 1'b1;
        drain(20);
        check("t5_dropped_sticky", dropped, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("t5_dropped_rst", dropped, 0);

        // Set/clear collision keeps the line pending without flagging a drop.
        out_ready = 1'b0;
        req = 8'h20; exp_q.push_back(3'd5);
        tick(); req = 8'h00;
        tick();
        check("t6_hold_code", out_code, 5);
        out_ready = 1'b1; req = 8'h20; exp_q.push_back(3'd5);
        tick(); req = 8'h00;
        check("t6_pending_kept", pending, 8'h20);
        check("t6_no_drop", dropped, 0);
        check("t6_gap_valid", out_valid, 0);
        tick();
        check("t6_repres_valid", out_valid, 1);
        check("t6_repres_code", out_code, 5);
        tick();
        check("t6_drain", exp_q.size(), 0);
        check("t6_pending_clear", pending, 8'h00);

        // Reset mid-HOLD discards the presented code.
        out_ready = 1'b0; req = 8'h02;
        tick(); req = 8'h00;
        tick();
        check("t6_hold_before_rst", out_valid, 1);
        rst = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b0;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_pending", pending, 8'h00);
        tick();
        check("t6_idle_after_rst", out_valid, 0);
        check("final_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
